imem_fetch_ctrl: RTL

Fetch sequencer for the word-addressed instruction ROM (8192 x 32, combinational read). Owns the program counter and drives the ROM read address every cycle. Registers the returned word into a one-entry fetch output stage for decode, and handles stalls, branch/jump redirects, a halt word and address faults. Sits between the ROM and the decode stage of the CPU.

---
 rtl/imem_fetch_ctrl.sv | 138 +++++++++++++
 1 files changed

// File: rtl/imem_fetch_ctrl.sv
// rtl/imem_fetch_ctrl.sv - instruction ROM fetch sequencer
//
// Owns the program counter, drives the ROM word address every cycle and
// registers the returned word into a one-entry fetch stage for decode.
// Handles decode stalls, branch/jump redirects, a halt word and address faults.
//
// Ports:
//   i_clk             clock, all state updates on the rising edge
//   i_rst             asynchronous active-high reset
//   i_stall           decode back-pressure, holds the fetch stage and PC
//   i_redirect_valid  branch/jump taken this cycle (beats i_stall)
//   i_redirect_target byte address of the redirect
//   o_mem_addr        ROM word index derived from the PC
//   i_mem_rdata       ROM word at o_mem_addr, same cycle
//   o_if_valid        o_if_instr/o_if_pc hold a live instruction
//   o_if_instr        fetched instruction
//   o_if_pc           byte PC of o_if_instr
//   o_halted          halt word fetched, sticky until reset
//   o_fault           misaligned/out-of-range PC, sticky until reset
//   o_fetch_count     instructions issued, wraps at 2^32

module imem_fetch_ctrl #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int          ADDR_W    = 13,
  parameter logic [31:0] HALT_WORD = 32'hFFFF_FFFF
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_stall,
  input  logic        i_redirect_valid,
  input  logic [31:0] i_redirect_target,
  output logic [31:0] o_mem_addr,
  input  logic [31:0] i_mem_rdata,
  output logic        o_if_valid,
  output logic [31:0] o_if_instr,
  output logic [31:0] o_if_pc,
  output logic        o_halted,
  output logic        o_fault,
  output logic [31:0] o_fetch_count
);

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_HALT  = 2'd1,
    ST_FAULT = 2'd2
  } state_t;

  state_t      r_state, w_state_nx;
  logic [31:0] r_pc, w_pc_nx;
  logic        r_if_valid, w_if_valid_nx;
  logic [31:0] r_if_instr, w_if_instr_nx;
  logic [31:0] r_if_pc, w_if_pc_nx;
  logic [31:0] r_fetch_count, w_fetch_count_nx;

  logic [31:0] w_pc_inc;
  logic        w_tgt_bad;
  logic        w_inc_bad;

  assign w_pc_inc = r_pc + 32'd4;

  // Any bit at or above ADDR_W+2 means the byte address lies past the ROM.
  assign w_tgt_bad = (i_redirect_target[1:0] != 2'b00) ||
                     ((i_redirect_target >> (ADDR_W + 2)) != 32'd0);
  assign w_inc_bad = (w_pc_inc >> (ADDR_W + 2)) != 32'd0;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state       <= ST_RUN;
      r_pc          <= RESET_PC;
      r_if_valid    <= 1'b0;
      r_if_instr    <= 32'd0;
      r_if_pc       <= 32'd0;
      r_fetch_count <= 32'd0;
    end else begin
      r_state       <= w_state_nx;
      r_pc          <= w_pc_nx;
      r_if_valid    <= w_if_valid_nx;
      r_if_instr    <= w_if_instr_nx;
      r_if_pc       <= w_if_pc_nx;
      r_fetch_count <= w_fetch_count_nx;
    end
  end

  always_comb begin
    w_state_nx       = r_state;
    w_pc_nx          = r_pc;
    w_if_valid_nx    = r_if_valid;
    w_if_instr_nx    = r_if_instr;
    w_if_pc_nx       = r_if_pc;
    w_fetch_count_nx = r_fetch_count;

    case (r_state)
      ST_RUN: begin
        if (i_redirect_valid) begin
          // The word fetched this cycle is wrong-path: squash it.
          w_if_valid_nx = 1'b0;
          if (w_tgt_bad) begin
            w_state_nx = ST_FAULT;
          end else begin
            w_pc_nx = i_redirect_target;
          end
        end else if (!i_stall) begin
          w_if_instr_nx    = i_mem_rdata;
          w_if_pc_nx       = r_pc;
          w_if_valid_nx    = 1'b1;
          w_fetch_count_nx = r_fetch_count + 32'd1;
          if (i_mem_rdata == HALT_WORD) begin
            w_state_nx = ST_HALT;
          end else if (w_inc_bad) begin
            // Last ROM word still issues; the PC never takes the bad value.
            w_state_nx = ST_FAULT;
          end else begin
            w_pc_nx = w_pc_inc;
          end
        end
      end
      ST_HALT: begin
        // Keep the halt word visible until decode accepts it.
        if (!i_stall) begin
          w_if_valid_nx = 1'b0;
        end
      end
      default: begin
        w_state_nx    = ST_FAULT;
        w_if_valid_nx = 1'b0;
      end
    endcase
  end

  assign o_mem_addr    = {{(32 - ADDR_W){1'b0}}, r_pc[ADDR_W+1:2]};
  assign o_if_valid    = r_if_valid;
  assign o_if_instr    = r_if_instr;
  assign o_if_pc       = r_if_pc;
  assign o_halted      = (r_state == ST_HALT);
  assign o_fault       = (r_state == ST_FAULT);
  assign o_fetch_count = r_fetch_count;

endmodule
